// File: rtl/fpu_add_subt_fsm.sv
// Control FSM for the floating-point add/subtract datapath.
// Responder side of the beg/ready/ack handshake: sequences operand load,
// exponent compare, alignment, mantissa add, iterative normalization,
// rounding and result load, then holds ready until the requester releases.
module fpu_add_subt_fsm #(
    parameter int unsigned MAX_NORM_SHIFTS = 26,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic beg_add_subt,
    input  logic ack_add_subt,
    input  logic zero_operand,
    input  logic mant_zero,
    input  logic mant_carry,
    input  logic mant_lead,
    output logic load_operands,
    output logic enab_exp_cmp,
    output logic enab_align,
    output logic enab_mant_add,
    output logic enab_norm,
    output logic shift_left_norm,
    output logic enab_round,
    output logic bypass_sel,
    output logic load_result,
    output logic ready_add_subt,
    output logic underflow_flag
);

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        ALIGN,
        ADD,
        NCHK,
        ROUND,
        LOAD,
        READY
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NORM_SHIFTS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beg_q;
    logic             bypass_q, bypass_d;
    logic             uflow_q, uflow_d;
    logic             start;

    // Rising edge of beg only; gated by reset so nothing fires in a reset cycle.
    assign start = reset & beg_add_subt & ~beg_q;

    assign underflow_flag = uflow_q;

    // State, counter, edge-detect and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beg_q    <= 1'b0;
            bypass_q <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beg_q    <= beg_add_subt;
            bypass_q <= bypass_d;
            uflow_q  <= uflow_d;
        end
    end

    // Next-state and output decode; NCHK outputs also depend on datapath flags.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bypass_d        = bypass_q;
        uflow_d         = uflow_q;
        load_operands   = 1'b0;
        enab_exp_cmp    = 1'b0;
        enab_align      = 1'b0;
        enab_mant_add   = 1'b0;
        enab_norm       = 1'b0;
        shift_left_norm = 1'b0;
        enab_round      = 1'b0;
        bypass_sel      = 1'b0;
        load_result     = 1'b0;
        ready_add_subt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_operands = 1'b1;
                    cnt_d         = '0;
                    uflow_d       = 1'b0;
                    bypass_d      = 1'b0;
                    state_d       = CMP;
                end
            end
            CMP: begin
                enab_exp_cmp = 1'b1;
                if (zero_operand) begin
                    bypass_d = 1'b1;
                    state_d  = LOAD;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                enab_align = 1'b1;
                state_d    = ADD;
            end
            ADD: begin
                enab_mant_add = 1'b1;
                cnt_d         = '0;
                state_d       = NCHK;
            end
            NCHK: begin
                if (mant_zero) begin
                    bypass_d = 1'b1;
                    state_d  = LOAD;
                end else if (mant_carry) begin
                    enab_norm = 1'b1;
                    state_d   = ROUND;
                end else if (mant_lead) begin
                    state_d = ROUND;
                end else if (cnt_q == CNT_MAX) begin
                    uflow_d = 1'b1;
                    state_d = ROUND;
                end else begin
                    enab_norm       = 1'b1;
                    shift_left_norm = 1'b1;
                    cnt_d           = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                enab_round = 1'b1;
                state_d    = LOAD;
            end
            LOAD: begin
                load_result = 1'b1;
                bypass_sel  = bypass_q;
                state_d     = READY;
            end
            READY: begin
                ready_add_subt = 1'b1;
                bypass_sel     = bypass_q;
                // Requester may release by dropping beg instead of acking.
                if (ack_add_subt || !beg_add_subt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_add_subt_fsm.sv
// Self-checking bench for fpu_add_subt_fsm: directed and randomized operations
// compared cycle by cycle against a schedule-based reference model.
module tb_fpu_add_subt_fsm;

    localparam int MAXN = 26;

    typedef struct packed {
        logic lo, ec, al, ma, nm, sl, rd, bs, lr, rdy, uf;
    } ovec_t;

    logic clk = 1'b0;
    logic reset, beg_add_subt, ack_add_subt;
    logic zero_operand, mant_zero, mant_carry, mant_lead;
    logic load_operands, enab_exp_cmp, enab_align, enab_mant_add, enab_norm;
    logic shift_left_norm, enab_round, bypass_sel, load_result;
    logic ready_add_subt, underflow_flag;
    ovec_t outv;

    int checks = 0;
    int errors = 0;
    bit uf_model = 1'b0;

    always #5 clk = ~clk;

    fpu_add_subt_fsm #(.MAX_NORM_SHIFTS(MAXN), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
        .zero_operand(zero_operand), .mant_zero(mant_zero),
        .mant_carry(mant_carry), .mant_lead(mant_lead),
        .load_operands(load_operands), .enab_exp_cmp(enab_exp_cmp),
        .enab_align(enab_align), .enab_mant_add(enab_mant_add),
        .enab_norm(enab_norm), .shift_left_norm(shift_left_norm),
        .enab_round(enab_round), .bypass_sel(bypass_sel),
        .load_result(load_result), .ready_add_subt(ready_add_subt),
        .underflow_flag(underflow_flag)
    );

    assign outv = {load_operands, enab_exp_cmp, enab_align, enab_mant_add, enab_norm,
                   shift_left_norm, enab_round, bypass_sel, load_result,
                   ready_add_subt, underflow_flag};

    // kind: 0 lead after nsh shifts, 1 carry, 2 mantissa zero, 3 zero operand, 4 underflow
    function automatic int load_cycle(input int kind, input int nsh);
        if (kind == 3) return 2;
        if (kind == 2) return 5;
        return 6 + nsh;
    endfunction

    // Expected outputs in cycle c of an operation (cycle 0 = start sampled).
    function automatic ovec_t exp_at(input int kind, input int nsh, input int c,
                                     input int rel_c, input bit uf_prev);
        ovec_t e;
        int t;
        int ld;
        e  = '0;
        t  = 4 + nsh;
        ld = load_cycle(kind, nsh);
        if (c == 0) e.lo = 1'b1;
        else if (c == 1) e.ec = 1'b1;
        else if (kind != 3) begin
            if (c == 2) e.al = 1'b1;
            if (c == 3) e.ma = 1'b1;
            if (c >= 4 && c < t) begin e.nm = 1'b1; e.sl = 1'b1; end
            if (c == t && kind == 1) e.nm = 1'b1;
            if (c == t + 1 && kind != 2) e.rd = 1'b1;
        end
        if (c == ld) e.lr = 1'b1;
        if (c > ld && c <= rel_c) e.rdy = 1'b1;
        if ((kind == 2 || kind == 3) && c >= ld && c <= rel_c) e.bs = 1'b1;
        e.uf = (c == 0) ? uf_prev : (kind == 4 && c > t);
        return e;
    endfunction

    task automatic chk(input ovec_t exp, input string tag, input int c);
        checks++;
        assert (outv === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, outv, exp);
        end
    endtask

    task automatic rnd_flags();
        zero_operand = 1'($urandom_range(0, 1));
        mant_zero    = 1'($urandom_range(0, 1));
        mant_carry   = 1'($urandom_range(0, 1));
        mant_lead    = 1'($urandom_range(0, 1));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int kind, input int nsh, input bit rel_ack,
                          input int m, input string tag);
        int ready_at, rel_c, t, total;
        bit uf_prev;
        uf_prev  = uf_model;
        ready_at = load_cycle(kind, nsh) + 1;
        rel_c    = ready_at + m;
        t        = 4 + nsh;
        total    = rel_c + (rel_ack ? 3 : 1);
        for (int c = 0; c <= total; c++) begin
            beg_add_subt = rel_ack ? (c <= rel_c + 2) : (c < rel_c);
            if (c >= ready_at && c <= rel_c) ack_add_subt = rel_ack && (c == rel_c);
            else ack_add_subt = 1'($urandom_range(0, 1));
            rnd_flags();
            if (c == 1) zero_operand = (kind == 3);
            if (kind != 3 && c >= 4 && c < t) begin
                mant_zero = 1'b0; mant_carry = 1'b0; mant_lead = 1'b0;
            end
            if (kind != 3 && c == t) begin
                case (kind)
                    0: begin mant_zero = 1'b0; mant_carry = 1'b0; mant_lead = 1'b1; end
                    1: begin mant_zero = 1'b0; mant_carry = 1'b1; end
                    2: mant_zero = 1'b1;
                    default: begin mant_zero = 1'b0; mant_carry = 1'b0; mant_lead = 1'b0; end
                endcase
            end
            @(negedge clk);
            chk(exp_at(kind, nsh, c, rel_c, uf_prev), tag, c);
            next_cycle();
        end
        uf_model = (kind == 4);
    endtask

    initial begin
        reset = 1'b0; beg_add_subt = 1'b0; ack_add_subt = 1'b0;
        zero_operand = 1'b0; mant_zero = 1'b0; mant_carry = 1'b0; mant_lead = 1'b0;

        // Power-on reset: everything low.
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk('0, "reset_state", 0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk('0, "post_reset_idle", 0);
        next_cycle();

        // Directed paths.
        run_op(0, 0, 1'b1, 2, "normal_ack");
        run_op(1, 0, 1'b0, 1, "carry");
        run_op(0, 3, 1'b1, 0, "lshift3");
        run_op(3, 0, 1'b0, 0, "bypass_zero_op");
        run_op(2, 0, 1'b1, 1, "mant_zero");
        run_op(0, MAXN, 1'b0, 0, "lead_at_limit");
        run_op(4, MAXN, 1'b0, 2, "underflow");
        run_op(0, 1, 1'b0, 2, "uf_clear_restart");

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            int kind, nsh;
            kind = int'($urandom_range(0, 4));
            nsh  = (kind == 0) ? int'($urandom_range(0, MAXN)) : ((kind == 4) ? MAXN : 0);
            run_op(kind, nsh, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
        end

        // Reset in the middle of normalization.
        beg_add_subt = 1'b1;
        ack_add_subt = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            zero_operand = (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (c >= 4) begin mant_zero = 1'b0; mant_carry = 1'b0; mant_lead = 1'b0; end
            else begin mant_zero = 1'b1; mant_carry = 1'b1; mant_lead = 1'b1; end
            @(negedge clk);
            chk(exp_at(4, MAXN, c, 100, uf_model), "pre_abort", c);
            next_cycle();
        end
        reset = 1'b0;
        beg_add_subt = 1'b0;
        next_cycle();
        @(negedge clk);
        chk('0, "abort_reset_low", 0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk('0, "abort_released", 0);
        next_cycle();
        uf_model = 1'b0;
        run_op(0, 2, 1'b1, 1, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
